// File: rtl/tdp_ram_clr.sv
// True dual-port RAM with registered read ports, write filtering,
// same-address write arbitration and a sequential clear engine.
module tdp_ram_clr #(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned READ_MODE      = 0,
    parameter int unsigned FILTER_EN      = 1,
    parameter int unsigned FILTER_VAL     = 32'h0d,
    parameter int unsigned CLEAR_VAL      = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  collision
);

    localparam int unsigned           DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] FILT_W = DATA_WIDTH'(FILTER_VAL);
    localparam logic [DATA_WIDTH-1:0] CLR_W  = DATA_WIDTH'(CLEAR_VAL);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_wr;
    logic                  clr_start;

    logic                  same_addr;
    logic                  filt_a, filt_b;
    logic                  wr_a, wr_b;
    logic                  dual_hit;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
    logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
    logic                  collision_q, collision_d;

    // Clear FSM state and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM next state: sweep every address once, clr ignored while sweeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        busy      = (state_q == CLEAR);
        clr_wr    = (state_q == CLEAR);
        clr_start = (state_q == IDLE) && clr;
    end

    // User write qualification: filter per port, port A wins a same-address tie
    always_comb begin
        same_addr = (addr_a == addr_b);
        filt_a    = (FILTER_EN != 0) && (din_a == FILT_W);
        filt_b    = (FILTER_EN != 0) && (din_b == FILT_W);
        dual_hit  = we_a && we_b && same_addr && !busy;
        wr_a      = we_a && !busy && !filt_a;
        wr_b      = we_b && !busy && !filt_b && !(we_a && same_addr);
    end

    // Memory array (not reset; only the clear engine initialises it)
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q] <= CLR_W;
        end else begin
            if (wr_a) begin
                mem[addr_a] <= din_a;
            end
            if (wr_b) begin
                mem[addr_b] <= din_b;
            end
        end
    end

    // Read data and collision next values; zeroed on the clear-start edge too
    // so the outputs read 0 for every busy cycle, including the first
    always_comb begin
        if (busy || clr_start) begin
            dout_a_d = '0;
        end else if ((READ_MODE != 0) && wr_a) begin
            dout_a_d = din_a;
        end else begin
            dout_a_d = mem[addr_a];
        end

        if (busy || clr_start) begin
            dout_b_d = '0;
        end else if ((READ_MODE != 0) && wr_b) begin
            dout_b_d = din_b;
        end else begin
            dout_b_d = mem[addr_b];
        end

        collision_d = dual_hit && !clr_start;
    end

    // Registered read ports and collision pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            collision_q <= collision_d;
        end
    end

    assign dout_a    = dout_a_q;
    assign dout_b    = dout_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_tdp_ram_clr.sv
// Directed bench for tdp_ram_clr. Two instances share the stimulus:
// u0 is read-first with filtering, u1 is write-first without filtering.
module tb_tdp_ram_clr;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       we_a, we_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;

    logic       busy0, busy1;
    logic [7:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic       col0, col1;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic       wa;
        logic       wb;
        logic [3:0] aa;
        logic [3:0] ab;
        logic [7:0] da;
        logic [7:0] db;
        logic [7:0] ea0;
        logic [7:0] eb0;
        logic [7:0] ea1;
        logic [7:0] eb1;
        logic       col;
    } vec_t;

    vec_t vt [14];

    tdp_ram_clr #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (8),
        .READ_MODE     (0),
        .FILTER_EN     (1),
        .FILTER_VAL    (32'h0d),
        .CLEAR_VAL     (32'hAA),
        .CLEAR_ON_RESET(1)
    ) u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy0),
        .we_a     (we_a),
        .we_b     (we_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .din_a    (din_a),
        .din_b    (din_b),
        .dout_a   (dout_a0),
        .dout_b   (dout_b0),
        .collision(col0)
    );

    tdp_ram_clr #(
        .ADDR_WIDTH    (4),
        .DATA_WIDTH    (8),
        .READ_MODE     (1),
        .FILTER_EN     (0),
        .FILTER_VAL    (32'h0d),
        .CLEAR_VAL     (32'hAA),
        .CLEAR_ON_RESET(1)
    ) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy1),
        .we_a     (we_a),
        .we_b     (we_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .din_a    (din_a),
        .din_b    (din_b),
        .dout_a   (dout_a1),
        .dout_b   (dout_b1),
        .collision(col1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"}, {30'd0, busy0, busy1}, 32'd3);
        chk({nm, "_dout"}, {dout_a0, dout_b0, dout_a1, dout_b1}, 32'd0);
        chk({nm, "_col"}, {30'd0, col0, col1}, 32'd0);
    endtask

    // Count busy cycles; optionally inject writes and a second clr mid-clear.
    task automatic count_busy(input bit lockout, output int n);
        n = 0;
        while (busy0 && n < 40) begin
            if (lockout && n == 5) begin
                we_a = 1'b1; we_b = 1'b1; addr_a = 4'd2; addr_b = 4'd2;
                din_a = 8'h55; din_b = 8'h77;
            end else begin
                we_a = 1'b0; we_b = 1'b0; addr_a = 4'd3; addr_b = 4'd7;
            end
            clr = lockout && (n == 8);
            tick();
            n++;
            chk($sformatf("busy_dout_c%0d", n), {dout_a0, dout_b0, dout_a1, dout_b1}, 32'd0);
            chk($sformatf("busy_col_c%0d", n), {29'd0, col0, col1, busy0 ^ busy1}, 32'd0);
        end
        we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
    endtask

    initial begin
        int n;

        //          wa  wb  aa     ab     da     db     ea0    eb0    ea1    eb1    col
        vt[0]  = '{1'b0, 1'b0, 4'd0,  4'd15, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 4'd3,  4'd3,  8'h41, 8'h00, 8'hAA, 8'hAA, 8'h41, 8'hAA, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 4'd3,  4'd3,  8'h0d, 8'h00, 8'h41, 8'h41, 8'h0d, 8'h41, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 4'd3,  4'd3,  8'h00, 8'h00, 8'h41, 8'h41, 8'h0d, 8'h0d, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 4'd5,  4'd5,  8'h00, 8'h11, 8'hAA, 8'hAA, 8'hAA, 8'h11, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 4'd5,  4'd5,  8'h22, 8'h00, 8'h11, 8'h11, 8'h22, 8'h11, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 4'd7,  4'd7,  8'h01, 8'h02, 8'hAA, 8'hAA, 8'h01, 8'hAA, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 4'd7,  4'd7,  8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 4'd8,  4'd8,  8'h0d, 8'h33, 8'hAA, 8'hAA, 8'h0d, 8'hAA, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 4'd8,  4'd8,  8'h00, 8'h00, 8'hAA, 8'hAA, 8'h0d, 8'h0d, 1'b0};
        vt[10] = '{1'b1, 1'b1, 4'd10, 4'd9,  8'h44, 8'h0d, 8'hAA, 8'hAA, 8'h44, 8'h0d, 1'b0};
        vt[11] = '{1'b0, 1'b0, 4'd9,  4'd10, 8'h00, 8'h00, 8'hAA, 8'h44, 8'h0d, 8'h44, 1'b0};
        vt[12] = '{1'b0, 1'b1, 4'd2,  4'd2,  8'h00, 8'h66, 8'hAA, 8'hAA, 8'hAA, 8'h66, 1'b0};
        vt[13] = '{1'b0, 1'b0, 4'd2,  4'd2,  8'h00, 8'h00, 8'h66, 8'h66, 8'h66, 8'h66, 1'b0};

        rst_n = 1'b1; clr = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        #1 rst_n = 1'b0;
        #2;
        chk_idle_outputs("reset");

        // Auto-clear on reset release
        tick(); tick();
        rst_n = 1'b1;
        count_busy(1'b0, n);
        chk("auto_clear_len", n, 32'd16);

        // Table vectors
        for (int i = 0; i < 14; i++) begin
            we_a = vt[i].wa; we_b = vt[i].wb;
            addr_a = vt[i].aa; addr_b = vt[i].ab;
            din_a = vt[i].da; din_b = vt[i].db;
            tick();
            chk($sformatf("vec%0d_a0", i), {24'd0, dout_a0}, {24'd0, vt[i].ea0});
            chk($sformatf("vec%0d_b0", i), {24'd0, dout_b0}, {24'd0, vt[i].eb0});
            chk($sformatf("vec%0d_a1", i), {24'd0, dout_a1}, {24'd0, vt[i].ea1});
            chk($sformatf("vec%0d_b1", i), {24'd0, dout_b1}, {24'd0, vt[i].eb1});
            chk($sformatf("vec%0d_col", i), {30'd0, col0, col1}, {30'd0, vt[i].col, vt[i].col});
        end
        we_a = 1'b0; we_b = 1'b0;

        // Clear lockout: writes and a repeated clr during busy are ignored
        addr_a = 4'd3; addr_b = 4'd7;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_start_busy", {30'd0, busy0, busy1}, 32'd3);
        chk("clr_start_dout", {dout_a0, dout_b0, dout_a1, dout_b1}, 32'd0);
        count_busy(1'b1, n);
        chk("lockout_len", n, 32'd16);
        addr_a = 4'd2; addr_b = 4'd3;
        tick();
        chk("lockout_rd", {dout_a0, dout_b0, dout_a1, dout_b1}, 32'hAAAAAAAA);

        // Async reset with live outputs: collision and dout drop at once
        we_a = 1'b1; we_b = 1'b1; addr_a = 4'd4; addr_b = 4'd4;
        din_a = 8'h12; din_b = 8'h34;
        tick();
        chk("pre_rst_col", {30'd0, col0, col1}, 32'd3);
        chk("pre_rst_dout", {dout_a0, dout_b0, dout_a1, dout_b1}, 32'hAAAA12AA);
        rst_n = 1'b0;
        we_a = 1'b0; we_b = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        tick(); tick();
        rst_n = 1'b1;
        count_busy(1'b0, n);
        chk("rst_clear_len", n, 32'd16);

        // Reset mid-clear at clear cycle 6 aborts and restarts the sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        chk("midclr_busy", {30'd0, busy0, busy1}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midclr_rst");
        tick(); tick();
        rst_n = 1'b1;
        count_busy(1'b0, n);
        chk("midclr_restart_len", n, 32'd16);

        // Whole memory holds the fill value
        for (int i = 0; i < 16; i++) begin
            addr_a = 4'(i);
            addr_b = 4'(15 - i);
            tick();
            chk($sformatf("fill_rd%0d", i), {dout_a0, dout_b0, dout_a1, dout_b1}, 32'hAAAAAAAA);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
